// File: rtl/exe_div_unit.sv
// Shared iterative radix-2 restoring divider for the execute stage.
// Arbitrates issue lanes, reports divide-by-zero, aborts on flush.
module exe_div_unit #(
  parameter int WIDTH    = 32,
  parameter int LANES    = 2,
  parameter int LANE_IDW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [LANES-1:0]       req_valid,
  input  logic [LANES-1:0]       req_signed,
  input  logic [LANES*WIDTH-1:0] req_dividend,
  input  logic [LANES*WIDTH-1:0] req_divisor,
  output logic [LANES-1:0]       req_accept,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANE_IDW-1:0]    out_lane,
  output logic [WIDTH-1:0]       out_quot,
  output logic [WIDTH-1:0]       out_rem,
  output logic                   out_div_by_zero,
  output logic                   busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t              state;
  logic [LANE_IDW-1:0] lane_q;
  logic                sgn_q;
  logic                dneg_q;
  logic                vneg_q;
  logic                zero_q;
  logic [WIDTH-1:0]    quot_q;
  logic [WIDTH-1:0]    rem_q;
  logic [WIDTH-1:0]    dvs_q;
  logic [WIDTH-1:0]    orig_q;
  logic [CW-1:0]       count_q;

  logic                take;
  logic [LANE_IDW-1:0] sel;
  logic                sel_sgn;
  logic [WIDTH-1:0]    sel_dvd;
  logic [WIDTH-1:0]    sel_dvs;
  logic                d_neg;
  logic                v_neg;
  logic [WIDTH:0]      trial;

  assign busy = (state != IDLE);

  // Fixed-priority pick of the lowest requesting lane (oldest first).
  always_comb begin
    req_accept = '0;
    sel        = '0;
    sel_sgn    = 1'b0;
    sel_dvd    = '0;
    sel_dvs    = '0;
    take       = 1'b0;
    if (state == IDLE && !flush && !reset) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_valid[i] && !take) begin
          take          = 1'b1;
          req_accept[i] = 1'b1;
          sel           = LANE_IDW'(i);
          sel_sgn       = req_signed[i];
          sel_dvd       = req_dividend[i*WIDTH +: WIDTH];
          sel_dvs       = req_divisor[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign d_neg = sel_sgn & sel_dvd[WIDTH-1];
  assign v_neg = sel_sgn & sel_dvs[WIDTH-1];

  // Trial subtract of the divisor from the shifted partial remainder.
  assign trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lane_q          <= '0;
      sgn_q           <= 1'b0;
      dneg_q          <= 1'b0;
      vneg_q          <= 1'b0;
      zero_q          <= 1'b0;
      quot_q          <= '0;
      rem_q           <= '0;
      dvs_q           <= '0;
      orig_q          <= '0;
      count_q         <= '0;
      out_valid       <= 1'b0;
      out_lane        <= '0;
      out_quot        <= '0;
      out_rem         <= '0;
      out_div_by_zero <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            lane_q  <= sel;
            sgn_q   <= sel_sgn;
            dneg_q  <= d_neg;
            vneg_q  <= v_neg;
            zero_q  <= (sel_dvs == '0);
            quot_q  <= d_neg ? -sel_dvd : sel_dvd;
            dvs_q   <= v_neg ? -sel_dvs : sel_dvs;
            orig_q  <= sel_dvd;
            rem_q   <= '0;
            count_q <= CW'(WIDTH - 1);
            state   <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem_q  <= trial[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q  <= {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
          end
          count_q <= count_q - CW'(1);
          if (count_q == '0) state <= FIX;
        end
        FIX: begin
          out_lane <= lane_q;
          if (zero_q) begin
            out_quot        <= '1;
            out_rem         <= orig_q;
            out_div_by_zero <= 1'b1;
          end else begin
            out_quot        <= (sgn_q && (dneg_q != vneg_q)) ? -quot_q : quot_q;
            out_rem         <= (sgn_q && dneg_q) ? -rem_q : rem_q;
            out_div_by_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed and random checks of exe_div_unit against an
// arithmetic reference model.
module tb_exe_div_unit;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int LI = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [L-1:0]   req_valid;
  logic [L-1:0]   req_signed;
  logic [L*W-1:0] req_dividend;
  logic [L*W-1:0] req_divisor;
  logic [L-1:0]   req_accept;
  logic           out_valid;
  logic           out_ready;
  logic [LI-1:0]  out_lane;
  logic [W-1:0]   out_quot;
  logic [W-1:0]   out_rem;
  logic           out_div_by_zero;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  exe_div_unit #(.WIDTH(W), .LANES(L), .LANE_IDW(LI)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_signed      (req_signed),
    .req_dividend    (req_dividend),
    .req_divisor     (req_divisor),
    .req_accept      (req_accept),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_lane        (out_lane),
    .out_quot        (out_quot),
    .out_rem         (out_rem),
    .out_div_by_zero (out_div_by_zero),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r,
                                output bit z);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic drive(input int lane, input bit s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    req_signed[lane]            = s;
    req_dividend[lane*W +: W]   = a;
    req_divisor[lane*W +: W]    = b;
    req_valid[lane]             = 1'b1;
  endtask

  // Present a single request, check it is taken, drop it after the edge.
  task automatic issue(input int lane, input bit s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [L-1:0] exp_acc;
    @(negedge clk);
    drive(lane, s, a, b);
    #1;
    exp_acc = '0;
    exp_acc[lane] = 1'b1;
    chk("accept", 64'(req_accept), 64'(exp_acc));
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  // Called just after the accepting edge; checks latency, result,
  // stability under backpressure and the return to idle.
  task automatic expect_result(input int lane, input bit s,
                               input logic [W-1:0] a,
                               input logic [W-1:0] b, input int hold);
    logic [W-1:0] q, r;
    bit           z;
    int           cnt;
    model(s, a, b, q, r, z);
    out_ready = (hold == 0);
    cnt = 0;
    @(negedge clk);
    while (!out_valid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("latency", 64'(cnt), 64'(W + 1));
    chk("lane", 64'(out_lane), 64'(lane));
    chk("quot", 64'(out_quot), 64'(q));
    chk("rem", 64'(out_rem), 64'(r));
    chk("dbz", 64'(out_div_by_zero), 64'(z));
    for (int i = 0; i < hold; i++) begin
      req_valid[0] = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_quot", 64'(out_quot), 64'(q));
      chk("hold_rem", 64'(out_rem), 64'(r));
      chk("hold_acc", 64'(req_accept), 64'd0);
      req_valid[0] = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run(input int lane, input bit s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int hold);
    issue(lane, s, a, b);
    expect_result(lane, s, a, b, hold);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           sel;
    reset        = 1'b1;
    flush        = 1'b0;
    req_valid    = '1;
    req_signed   = '0;
    req_dividend = '0;
    req_divisor  = '0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", 64'(req_accept), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_quot", 64'(out_quot), 64'd0);
    chk("rst_rem", 64'(out_rem), 64'd0);
    chk("rst_lane", 64'(out_lane), 64'd0);
    chk("rst_dbz", 64'(out_div_by_zero), 64'd0);
    req_valid = '0;
    reset     = 1'b0;

    run(0, 1'b0, 32'd100, 32'd7, 0);
    run(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(0, 1'b0, 32'h1234_5678, 32'd0, 0);
    run(1, 1'b1, 32'h1234_5678, 32'd0, 0);
    run(0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);

    // Two lanes at once: lane 0 wins, lane 1 waits for its turn.
    @(negedge clk);
    drive(0, 1'b0, 32'd20, 32'd3);
    drive(1, 1'b0, 32'd9, 32'd4);
    #1;
    chk("dual_acc0", 64'(req_accept), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    expect_result(0, 1'b0, 32'd20, 32'd3, 0);
    chk("dual_acc1", 64'(req_accept), 64'd2);
    @(posedge clk);
    #1;
    req_valid = '0;
    expect_result(1, 1'b0, 32'd9, 32'd4, 0);

    // Flush mid-calculation beats a same-cycle request.
    issue(0, 1'b0, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    drive(0, 1'b0, 32'd50, 32'd5);
    #1;
    chk("flush_acc", 64'(req_accept), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("post_flush_acc", 64'(req_accept), 64'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    expect_result(0, 1'b0, 32'd50, 32'd5, 0);

    // Backpressure for five cycles.
    run(1, 1'b1, 32'hFFFF_FF00, 32'd7, 5);

    // Reset during calculation.
    issue(0, 1'b0, 32'd77, 32'd5);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_quot", 64'(out_quot), 64'd0);
    chk("mid_rst_rem", 64'(out_rem), 64'd0);
    chk("mid_rst_lane", 64'(out_lane), 64'd0);
    chk("mid_rst_dbz", 64'(out_div_by_zero), 64'd0);

    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      sel = $urandom_range(0, 4);
      if (sel == 0) b = '0;
      else if (sel == 1) b = W'($urandom_range(1, 15));
      else if (sel == 2) b = '1;
      else b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run($urandom_range(0, L - 1), 1'($urandom_range(0, 1)), a, b,
          $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_div_unit.md
Name: exe_div_unit

Overview:
- Shared iterative radix-2 divider for the execute stage. Serves LANES issue lanes; lane 0 is always the older instruction of the issue group.
- Replaces the per-lane dividers in the dual-issue EXE stage. Width and lane count are parametrised.
- Adds arbitration, result backpressure, divide-by-zero reporting and flush abort.
- Feeds HI/LO writeback via the pre-memory stage.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
LANES, 2, number of requesting issue lanes (>=1)
LANE_IDW, 1, width of lane index; must satisfy 2**LANE_IDW >= LANES

Ports:
clk  in  1  clock
reset  in  1  reset
flush  in  1  pipeline clear (exception/eret); aborts the current operation
req_valid  in  LANES  per-lane divide request
req_signed  in  LANES  1 = DIV (signed), 0 = DIVU
req_dividend  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
req_divisor  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
req_accept  out  LANES  one-hot; request taken this cycle
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_lane  out  LANE_IDW  lane that issued the result
out_quot  out  WIDTH  quotient (LO)
out_rem  out  WIDTH  remainder (HI)
out_div_by_zero  out  1  divisor was zero
busy  out  1  state != IDLE

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: state=IDLE; out_valid=0, out_lane=0, out_quot=0, out_rem=0, out_div_by_zero=0, busy=0; req_accept=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_accept[i]=1 for the lowest i with req_valid[i], only when state==IDLE and flush==0. Combinational, same cycle.
  - On accept: latch lane id, signed flag, operand signs, |dividend|, |divisor|, original dividend, zero-divisor flag. Clear the partial remainder. Load count=WIDTH-1. Go to CALC.
  - Absolute values apply only when signed. Most-negative input is treated as unsigned 2**(WIDTH-1).
- CALC:
  - One restoring step per cycle: shift {rem,quot} left by 1, trial-subtract divisor, set the quotient bit if non-negative.
  - count decrements each cycle. After the step with count==0 (exactly WIDTH cycles), go to FIX.
- FIX: one cycle to form the final results, then go to DONE.
  - Signed: quot negated if dividend sign != divisor sign; rem negated if dividend negative.
  - Divide by zero: out_quot={WIDTH{1}}, out_rem=original dividend, out_div_by_zero=1. Applies to both signed and unsigned.
  - Signed most-negative / -1: out_quot=most-negative, out_rem=0, out_div_by_zero=0.
- DONE:
  - out_valid=1. out_* held stable while out_ready=0.
  - out_valid&out_ready: go to IDLE. A new request can be accepted in the following cycle, not the same one.
- Latency: accept in cycle T gives out_valid first high in cycle T+WIDTH+2.
- out_* are registered and keep their last value after handshake until the next FIX. Only out_valid qualifies them.
- Flush:
  - Any state goes to IDLE on the next edge; out_valid drops then.
  - flush beats a same-cycle accept (no accept) and beats a same-cycle handshake. A result in DONE is discarded.
- reset mid-operation behaves like flush and additionally clears all outputs to reset values.
- Unselected lanes are not accepted; a requester holds req_valid until it sees its accept bit.

Test Plan:
- Unsigned 100/7 on lane 0, WIDTH=32, accept at T -> out_valid at T+34; quot=14, rem=2, lane=0, dbz=0.
- Signed -7/2 (0xFFFFFFF9 / 2) on lane 1 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF, lane=1. Also 0x80000000 / 0xFFFFFFFF signed -> quot=0x80000000, rem=0.
- Both lanes request in the same cycle, lane0 20/3 and lane1 9/4:
  - req_accept=2'b01; lane 0 result quot=6, rem=2.
  - lane 1 accepted the cycle after the lane-0 handshake; result quot=2, rem=1, lane=1.
- Divisor 0, dividend 0x12345678, unsigned then signed -> quot=0xFFFFFFFF, rem=0x12345678, dbz=1 in both cases.
- flush asserted 10 cycles into CALC -> busy=0 and out_valid=0 next cycle; no result ever appears. A request in the flush cycle is not accepted; it is accepted the following cycle.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and out_* stable, no accept. Handshake on cycle 6, IDLE next cycle. Also check a reset pulse during CALC returns all outputs to 0.
